// File: rtl/decodificador_hamming_param_pkg.sv
// Shared types and helpers for the parametrised Hamming SEC-DED decoder.
// The functions work on MAX_W-wide vectors so any instance width up to MAX_W can use them.
package decodificador_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int PAR_W_DEF  = 3;
  localparam int SECDED_DEF = 1;
  localparam int HW         = DATA_W_DEF + PAR_W_DEF;
  localparam int CW_W       = HW + SECDED_DEF;

  localparam int MAX_W = 64;
  localparam int MAX_P = 7;

  typedef enum logic [1:0] {
    LIMPO    = 2'd0,
    SIMPLES  = 2'd1,
    PARIDADE = 2'd2,
    DUPLO    = 2'd3
  } classe_t;

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Syndrome = XOR of the (1-based) positions of every set bit among the hw Hamming positions.
  function automatic logic [MAX_P-1:0] calc_sindrome(input logic [MAX_W-1:0] cw, input int hw);
    logic [MAX_P-1:0] s;
    logic [MAX_W-1:0] bit_i;
    s = '0;
    for (int i = 0; i < MAX_W; i++) begin
      bit_i = (cw >> i) & MAX_W'(1);
      if ((i < hw) && (bit_i != '0)) begin
        s = s ^ MAX_P'(i + 1);
      end
    end
    return s;
  endfunction

  // Packs the non-power-of-2 positions in ascending order into the low data bits.
  function automatic logic [MAX_W-1:0] extract_data(input logic [MAX_W-1:0] cw, input int hw);
    logic [MAX_W-1:0] d;
    logic [MAX_W-1:0] bit_i;
    int k;
    d = '0;
    k = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < hw) && !is_pow2(i + 1)) begin
        bit_i = (cw >> i) & MAX_W'(1);
        d     = d | (bit_i << k);
        k     = k + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/decodificador_hamming_param_sindrome.sv
// Combinational syndrome and overall-parity-error generator for one codeword.
module hamming_sindrome
  import decodificador_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int SECDED = 1,
  localparam int HW    = DATA_W + PAR_W,
  localparam int CW_W  = HW + SECDED
) (
  input  logic [CW_W-1:0]  codigo,
  output logic [PAR_W-1:0] sindrome,
  output logic             paridade_erro
);

  assign sindrome = PAR_W'(calc_sindrome(MAX_W'(codigo), HW));

  // Without the extra parity bit there is nothing to check, so report no parity error.
  assign paridade_erro = (SECDED != 0) ? (^codigo) : 1'b0;

endmodule

// File: rtl/decodificador_hamming_param.sv
// Two-stage pipelined parametrised Hamming SEC/SEC-DED decoder with saturating error counters.
// S1 registers the codeword with its syndrome/parity; S2 classifies, corrects and counts.
module decodificador_hamming_param
  import decodificador_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int SECDED = 1,
  parameter int CNT_W  = 8,
  localparam int HW    = DATA_W + PAR_W,
  localparam int CW_W  = HW + SECDED
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Controle,
  input  logic              Modo,
  input  logic              Limpa,
  input  logic [CW_W-1:0]   Entrada,
  input  logic              Entrada_valida,
  output logic [DATA_W-1:0] Saida,
  output logic              Saida_valida,
  output logic [PAR_W-1:0]  Sindrome,
  output logic              Erro_simples,
  output logic              Erro_duplo,
  output logic [CNT_W-1:0]  Cnt_simples,
  output logic [CNT_W-1:0]  Cnt_duplo
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((2 ** PAR_W) < (HW + 1)) begin : g_chk_par
    $error("PAR_W too small: 2**PAR_W must be >= DATA_W+PAR_W+1");
  end
  if ((CW_W > MAX_W) || (PAR_W > MAX_P)) begin : g_chk_max
    $error("codeword wider than the package helper functions support");
  end

  logic [PAR_W-1:0] sindrome_c;
  logic             pe_c;

  hamming_sindrome #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .SECDED (SECDED)
  ) u_sindrome (
    .codigo        (Entrada),
    .sindrome      (sindrome_c),
    .paridade_erro (pe_c)
  );

  logic [CW_W-1:0]  s1_codigo;
  logic             s1_valido;
  logic             s1_modo;
  logic [PAR_W-1:0] s1_sindrome;
  logic             s1_pe;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1_codigo   <= '0;
      s1_valido   <= 1'b0;
      s1_modo     <= 1'b0;
      s1_sindrome <= '0;
      s1_pe       <= 1'b0;
    end else if (Controle) begin
      s1_codigo   <= Entrada;
      s1_valido   <= Entrada_valida;
      s1_modo     <= Modo;
      s1_sindrome <= sindrome_c;
      s1_pe       <= pe_c;
    end
  end

  classe_t          classe;
  logic             fora_faixa;
  logic [CW_W-1:0]  codigo_corr;
  logic [DATA_W-1:0] dado;
  logic             erro_simples_c;
  logic             erro_duplo_c;

  // A syndrome beyond the last real position can only come from a multi-bit error in a shortened code.
  always_comb begin
    classe     = LIMPO;
    fora_faixa = int'(s1_sindrome) > HW;
    if (SECDED != 0) begin
      if (s1_sindrome == '0) begin
        classe = s1_pe ? PARIDADE : LIMPO;
      end else if (fora_faixa || !s1_pe) begin
        classe = DUPLO;
      end else begin
        classe = SIMPLES;
      end
    end else begin
      if (s1_sindrome == '0) begin
        classe = LIMPO;
      end else if (fora_faixa) begin
        classe = DUPLO;
      end else begin
        classe = SIMPLES;
      end
    end
  end

  always_comb begin
    codigo_corr = s1_codigo;
    if ((classe == SIMPLES) && !s1_modo) begin
      codigo_corr = s1_codigo ^ (CW_W'(1) << (s1_sindrome - 1'b1));
    end
  end

  assign dado           = DATA_W'(extract_data(MAX_W'(codigo_corr), HW));
  assign erro_simples_c = (classe == SIMPLES) || (classe == PARIDADE);
  assign erro_duplo_c   = (classe == DUPLO);

  // Bubbles clear the flags but leave Saida and Sindrome showing the last real word.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Saida        <= '0;
      Saida_valida <= 1'b0;
      Sindrome     <= '0;
      Erro_simples <= 1'b0;
      Erro_duplo   <= 1'b0;
    end else if (Controle) begin
      if (s1_valido) begin
        Saida        <= dado;
        Saida_valida <= 1'b1;
        Sindrome     <= s1_sindrome;
        Erro_simples <= erro_simples_c;
        Erro_duplo   <= erro_duplo_c;
      end else begin
        Saida_valida <= 1'b0;
        Erro_simples <= 1'b0;
        Erro_duplo   <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle increment; a stalled pipeline ignores both.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Cnt_simples <= '0;
      Cnt_duplo   <= '0;
    end else if (Controle) begin
      if (Limpa) begin
        Cnt_simples <= '0;
        Cnt_duplo   <= '0;
      end else begin
        if (s1_valido && erro_simples_c && (Cnt_simples != CNT_MAX)) begin
          Cnt_simples <= Cnt_simples + 1'b1;
        end
        if (s1_valido && erro_duplo_c && (Cnt_duplo != CNT_MAX)) begin
          Cnt_duplo <= Cnt_duplo + 1'b1;
        end
      end
    end
  end

endmodule
